// File: rtl/pps_timer_nco.sv
// pps_timer_nco: phase-accumulator NCO timer with periodic pulse output and pps_in timestamp capture.
// Define PPS_TIMER_TRIM_EN to make the increment table writable at runtime; otherwise it is constant.
module pps_timer_nco #(
  parameter int ACC_W = 32,
  parameter int TS_W = 64,
  parameter int TIME_INCR_VAL = 10,
  parameter int PPS_COUNT_VAL = 100000,
  parameter int PULSE_LEN = 8,
  parameter int NUM_INCR = 4,
  parameter logic [NUM_INCR*ACC_W-1:0] A_INCR_TABLE =
    {32'hd554c987, 32'hd5543db8, 32'hd553b1ea, 32'hd5555555}
) (
  input  logic                        clk_pps,
  input  logic                        reset_pps,
  input  logic                        sel_next,
  input  logic                        sel_load,
  input  logic [$clog2(NUM_INCR)-1:0] sel_val,
  input  logic                        incr_we,
  input  logic [$clog2(NUM_INCR)-1:0] incr_idx,
  input  logic [ACC_W-1:0]            incr_data,
  input  logic                        pps_in,
  input  logic                        ts_ack,
  output logic [$clog2(NUM_INCR)-1:0] a_incr_sel,
  output logic                        tick,
  output logic [TS_W-1:0]             timestamp,
  output logic [TS_W-1:0]             ts_capture,
  output logic                        ts_valid,
  output logic                        ts_overrun,
  output logic                        pps_pulse_out
);

  localparam int SEL_W = $clog2(NUM_INCR);
  localparam int CNT_W = $clog2(PPS_COUNT_VAL);
  localparam int PL_W  = $clog2(PULSE_LEN + 1);
  localparam logic [SEL_W:0] NUM_SEL = (SEL_W+1)'(NUM_INCR);

  logic [ACC_W-1:0] incr_tbl [NUM_INCR];
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic [CNT_W-1:0] cnt;
  logic [PL_W-1:0]  pulse_cnt;
  logic             sync1, sync2, sync3;
  logic             pps_rise;
  logic             terminal;

`ifdef PPS_TIMER_TRIM_EN
  always_ff @(posedge clk_pps) begin
    if (reset_pps) begin
      for (int i = 0; i < NUM_INCR; i++) begin
        incr_tbl[i] <= A_INCR_TABLE[i*ACC_W +: ACC_W];
      end
    end else if (incr_we && ({1'b0, incr_idx} < NUM_SEL)) begin
      incr_tbl[incr_idx] <= incr_data;
    end
  end
`else
  logic unused_trim;
  assign unused_trim = ^{incr_we, incr_idx, incr_data};

  for (genvar i = 0; i < NUM_INCR; i++) begin : g_tbl
    assign incr_tbl[i] = A_INCR_TABLE[i*ACC_W +: ACC_W];
  end
`endif

  // The carry out of the phase add is the fractional-rate tick.
  assign sum = {1'b0, acc} + {1'b0, incr_tbl[a_incr_sel]};

  always_ff @(posedge clk_pps) begin
    if (reset_pps) begin
      acc  <= '0;
      tick <= 1'b0;
    end else begin
      acc  <= sum[ACC_W-1:0];
      tick <= sum[ACC_W];
    end
  end

  assign terminal = tick && (cnt == CNT_W'(PPS_COUNT_VAL - 1));

  always_ff @(posedge clk_pps) begin
    if (reset_pps) begin
      timestamp <= '0;
      cnt       <= '0;
      pulse_cnt <= '0;
    end else begin
      if (tick) begin
        timestamp <= timestamp + TS_W'(TIME_INCR_VAL);
        cnt       <= terminal ? '0 : cnt + CNT_W'(1);
      end
      if (terminal) begin
        pulse_cnt <= PL_W'(PULSE_LEN);
      end else if (pulse_cnt != '0) begin
        pulse_cnt <= pulse_cnt - PL_W'(1);
      end
    end
  end

  assign pps_pulse_out = (pulse_cnt != '0);

  // A load with an out-of-range value still blocks sel_next that cycle.
  always_ff @(posedge clk_pps) begin
    if (reset_pps) begin
      a_incr_sel <= '0;
    end else if (sel_load) begin
      if ({1'b0, sel_val} < NUM_SEL) begin
        a_incr_sel <= sel_val;
      end
    end else if (sel_next) begin
      a_incr_sel <= (a_incr_sel == SEL_W'(NUM_INCR - 1)) ? '0 : a_incr_sel + SEL_W'(1);
    end
  end

  assign pps_rise = sync2 & ~sync3;

  always_ff @(posedge clk_pps) begin
    if (reset_pps) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      ts_capture <= '0;
      ts_valid   <= 1'b0;
      ts_overrun <= 1'b0;
    end else begin
      sync1 <= pps_in;
      sync2 <= sync1;
      sync3 <= sync2;
      if (pps_rise) begin
        if (!ts_valid || ts_ack) begin
          ts_capture <= timestamp;
          ts_valid   <= 1'b1;
        end else begin
          ts_overrun <= 1'b1;
        end
      end else if (ts_ack) begin
        ts_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pps_timer_nco.sv
// Directed bench for pps_timer_nco: several instances with different parameters share one clock and reset.
// Expected values come from hand-derived formulas and constants for each configuration.
module tb_pps_timer_nco;

  logic clk_pps = 1'b0;
  logic reset_pps;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk_pps = ~clk_pps;

  // dut_a: ACC_W=4, entry0=8 -> tick every 2nd cycle; 8-bit timestamp for wrap.
  logic [1:0] a_sel;
  logic       a_tick, a_valid, a_ovr, a_pulse;
  logic [7:0] a_ts, a_cap;

  pps_timer_nco #(.ACC_W(4), .TS_W(8), .TIME_INCR_VAL(10), .PPS_COUNT_VAL(4), .PULSE_LEN(2),
                  .NUM_INCR(4), .A_INCR_TABLE(16'h3218)) dut_a (
    .clk_pps(clk_pps), .reset_pps(reset_pps), .sel_next(1'b0), .sel_load(1'b0), .sel_val(2'd0),
    .incr_we(1'b0), .incr_idx(2'd0), .incr_data(4'h0), .pps_in(1'b0), .ts_ack(1'b0),
    .a_incr_sel(a_sel), .tick(a_tick), .timestamp(a_ts), .ts_capture(a_cap),
    .ts_valid(a_valid), .ts_overrun(a_ovr), .pps_pulse_out(a_pulse));

  // dut_c: same rate as dut_a, used for the capture handshake.
  logic        c_pps, c_ack;
  logic [1:0]  c_sel;
  logic        c_tick, c_valid, c_ovr, c_pulse;
  logic [15:0] c_ts, c_cap;

  pps_timer_nco #(.ACC_W(4), .TS_W(16), .TIME_INCR_VAL(10), .PPS_COUNT_VAL(4), .PULSE_LEN(2),
                  .NUM_INCR(4), .A_INCR_TABLE(16'h3218)) dut_c (
    .clk_pps(clk_pps), .reset_pps(reset_pps), .sel_next(1'b0), .sel_load(1'b0), .sel_val(2'd0),
    .incr_we(1'b0), .incr_idx(2'd0), .incr_data(4'h0), .pps_in(c_pps), .ts_ack(c_ack),
    .a_incr_sel(c_sel), .tick(c_tick), .timestamp(c_ts), .ts_capture(c_cap),
    .ts_valid(c_valid), .ts_overrun(c_ovr), .pps_pulse_out(c_pulse));

  // dut_d: all defaults.
  logic [1:0]  d_sel;
  logic        d_tick, d_valid, d_ovr, d_pulse;
  logic [63:0] d_ts, d_cap;

  pps_timer_nco dut_d (
    .clk_pps(clk_pps), .reset_pps(reset_pps), .sel_next(1'b0), .sel_load(1'b0), .sel_val(2'd0),
    .incr_we(1'b0), .incr_idx(2'd0), .incr_data(32'h0), .pps_in(1'b0), .ts_ack(1'b0),
    .a_incr_sel(d_sel), .tick(d_tick), .timestamp(d_ts), .ts_capture(d_cap),
    .ts_valid(d_valid), .ts_overrun(d_ovr), .pps_pulse_out(d_pulse));

  // dut_s4: select sequencing with NUM_INCR=4.
  logic       s4_next, s4_load;
  logic [1:0] s4_val, s4_sel;
  logic       s4_tick, s4_valid, s4_ovr, s4_pulse;
  logic [7:0] s4_ts, s4_cap;

  pps_timer_nco #(.ACC_W(4), .TS_W(8), .PPS_COUNT_VAL(4), .PULSE_LEN(2),
                  .NUM_INCR(4), .A_INCR_TABLE(16'h3218)) dut_s4 (
    .clk_pps(clk_pps), .reset_pps(reset_pps), .sel_next(s4_next), .sel_load(s4_load), .sel_val(s4_val),
    .incr_we(1'b0), .incr_idx(2'd0), .incr_data(4'h0), .pps_in(1'b0), .ts_ack(1'b0),
    .a_incr_sel(s4_sel), .tick(s4_tick), .timestamp(s4_ts), .ts_capture(s4_cap),
    .ts_valid(s4_valid), .ts_overrun(s4_ovr), .pps_pulse_out(s4_pulse));

  // dut_s3: NUM_INCR=3 so a 2-bit sel_val of 3 is out of range.
  logic       s3_next, s3_load;
  logic [1:0] s3_val, s3_sel;
  logic       s3_tick, s3_valid, s3_ovr, s3_pulse;
  logic [7:0] s3_ts, s3_cap;

  pps_timer_nco #(.ACC_W(4), .TS_W(8), .PPS_COUNT_VAL(4), .PULSE_LEN(2),
                  .NUM_INCR(3), .A_INCR_TABLE(12'h218)) dut_s3 (
    .clk_pps(clk_pps), .reset_pps(reset_pps), .sel_next(s3_next), .sel_load(s3_load), .sel_val(s3_val),
    .incr_we(1'b0), .incr_idx(2'd0), .incr_data(4'h0), .pps_in(1'b0), .ts_ack(1'b0),
    .a_incr_sel(s3_sel), .tick(s3_tick), .timestamp(s3_ts), .ts_capture(s3_cap),
    .ts_valid(s3_valid), .ts_overrun(s3_ovr), .pps_pulse_out(s3_pulse));

  // dut_t: table writes, NUM_INCR=3 so index 3 is out of range.
  logic       t_we;
  logic [1:0] t_idx, t_sel;
  logic [3:0] t_data;
  logic       t_tick, t_valid, t_ovr, t_pulse;
  logic [7:0] t_ts, t_cap;

  pps_timer_nco #(.ACC_W(4), .TS_W(8), .PPS_COUNT_VAL(4), .PULSE_LEN(2),
                  .NUM_INCR(3), .A_INCR_TABLE(12'h218)) dut_t (
    .clk_pps(clk_pps), .reset_pps(reset_pps), .sel_next(1'b0), .sel_load(1'b0), .sel_val(2'd0),
    .incr_we(t_we), .incr_idx(t_idx), .incr_data(t_data), .pps_in(1'b0), .ts_ack(1'b0),
    .a_incr_sel(t_sel), .tick(t_tick), .timestamp(t_ts), .ts_capture(t_cap),
    .ts_valid(t_valid), .ts_overrun(t_ovr), .pps_pulse_out(t_pulse));

  // Advance n clock edges, sampling 1 time unit after each rising edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_pps);
      #1;
      cyc++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Timestamp of the 4'h8 instances after edge n following reset release.
  function automatic int ts_model(input int n);
    return (n < 1) ? 0 : ((n - 1) / 2) * 10;
  endfunction

  function automatic logic pulse_model(input int n);
    return (n >= 9) && ((n % 8 == 1) || (n % 8 == 2));
  endfunction

  int ticks;
  int c0;
  int cap1;
  int r;
  logic [1:0] sel_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    reset_pps = 1'b1;
    c_pps = 0; c_ack = 0;
    s4_next = 0; s4_load = 0; s4_val = 0;
    s3_next = 0; s3_load = 0; s3_val = 0;
    t_we = 0; t_idx = 0; t_data = 0;
    applyStimulus(2);
    reset_pps = 1'b0;
    cyc = 0;

    $display("[TB] reset state");
    checkOutput("rst_a_tick", a_tick, 0);
    checkOutput("rst_a_ts", a_ts, 0);
    checkOutput("rst_a_pulse", a_pulse, 0);
    checkOutput("rst_a_sel", a_sel, 0);
    checkOutput("rst_c_valid", c_valid, 0);
    checkOutput("rst_c_ovr", c_ovr, 0);
    checkOutput("rst_c_cap", c_cap, 0);
    checkOutput("rst_d_acc", dut_d.acc, 0);

    $display("[TB] tick / timestamp / pulse, 8-bit wrap");
    for (int n = 1; n <= 53; n++) begin
      applyStimulus(1);
      checkOutput($sformatf("a_tick_%0d", n), a_tick, (n % 2 == 0));
      checkOutput($sformatf("a_ts_%0d", n), a_ts, ts_model(n) % 256);
      checkOutput($sformatf("a_pulse_%0d", n), a_pulse, pulse_model(n));
      if (n == 30) begin
        // 30 adds of 0xd5555555 = 25*2^32 - 10; 29 adds give 24 carries.
        checkOutput("d_acc_30", dut_d.acc, 64'h0000_0000_FFFF_FFF6);
        checkOutput("d_ts_30", d_ts, 64'd240);
        checkOutput("d_tick_30", d_tick, 0);
        checkOutput("d_sel_30", d_sel, 0);
      end
    end
    checkOutput("a_ts_wrap", a_ts, 8'd4);

    $display("[TB] select sequencing");
    s4_next = 1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("s4_next_%0d", i), s4_sel, sel_seq[i]);
    end
    s4_load = 1; s4_val = 2'd2;
    applyStimulus(1);
    checkOutput("s4_load_wins", s4_sel, 2'd2);
    s4_load = 0; s4_next = 0;
    applyStimulus(1);
    checkOutput("s4_hold", s4_sel, 2'd2);

    s3_load = 1; s3_val = 2'd3;
    applyStimulus(1);
    checkOutput("s3_load_oor", s3_sel, 2'd0);
    s3_val = 2'd2;
    applyStimulus(1);
    checkOutput("s3_load_2", s3_sel, 2'd2);
    s3_load = 0; s3_next = 1;
    applyStimulus(1);
    checkOutput("s3_next_wrap", s3_sel, 2'd0);
    s3_next = 0;

    $display("[TB] increment table writes");
    t_we = 1; t_idx = 2'd3; t_data = 4'h4;
    applyStimulus(1);
    t_we = 0;
    applyStimulus(1);
    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1);
      ticks += int'(t_tick);
    end
    checkOutput("t_oor_ticks", ticks, 8);

    t_we = 1; t_idx = 2'd0; t_data = 4'h4;
    applyStimulus(1);
    t_we = 0;
    applyStimulus(1);
    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1);
      ticks += int'(t_tick);
    end
`ifdef PPS_TIMER_TRIM_EN
    checkOutput("t_trim_ticks", ticks, 4);
`else
    checkOutput("t_trim_ticks", ticks, 8);
`endif

    $display("[TB] capture handshake");
    c0 = cyc;
    c_pps = 1;
    applyStimulus(2);
    checkOutput("cap_valid_early", c_valid, 0);
    applyStimulus(1);
    cap1 = ts_model(c0 + 2);
    checkOutput("cap1_valid", c_valid, 1);
    checkOutput("cap1_value", c_cap, 16'(cap1));
    checkOutput("cap1_ovr", c_ovr, 0);

    c_pps = 0;
    applyStimulus(4);
    c_pps = 1;
    applyStimulus(3);
    checkOutput("cap2_held", c_cap, 16'(cap1));
    checkOutput("cap2_valid", c_valid, 1);
    checkOutput("cap2_ovr", c_ovr, 1);

    c_pps = 0;
    applyStimulus(4);
    r = cyc;
    c_pps = 1;
    applyStimulus(2);
    c_ack = 1;
    applyStimulus(1);
    c_ack = 0;
    checkOutput("cap3_value", c_cap, 16'(ts_model(r + 2)));
    checkOutput("cap3_valid", c_valid, 1);

    c_ack = 1;
    applyStimulus(1);
    c_ack = 0;
    checkOutput("ack_clears", c_valid, 0);
    checkOutput("ovr_sticky", c_ovr, 1);

    $display("[TB] reset mid-pulse");
    while (cyc % 8 != 1) applyStimulus(1);
    checkOutput("a_pulse_before_rst", a_pulse, 1);
    reset_pps = 1'b1;
    applyStimulus(1);
    checkOutput("mid_rst_pulse", a_pulse, 0);
    checkOutput("mid_rst_tick", a_tick, 0);
    checkOutput("mid_rst_ts", a_ts, 0);
    checkOutput("mid_rst_c_valid", c_valid, 0);
    checkOutput("mid_rst_c_ovr", c_ovr, 0);
    checkOutput("mid_rst_c_cap", c_cap, 0);
    checkOutput("mid_rst_s4_sel", s4_sel, 0);
    reset_pps = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pps_timer_nco.md
# pps_timer_nco

Parametrised PPS timer core: a phase-accumulator NCO derives a fractional count clock from `clk_pps`, advances a wide timestamp, emits a periodic pulse and timestamps rising edges of `pps_in`. It generalises the fixed four-increment timer with parameter-sized accumulator, timestamp and increment table, direct select load, a capture handshake and optional runtime trimming of the increment table. It sits between the PLL/reset logic and board I/O in the top level.

## Interface
- `ACC_W`, 32: accumulator and increment width.
- `TS_W`, 64: timestamp width.
- `TIME_INCR_VAL`, 10: timestamp increment per tick.
- `PPS_COUNT_VAL`, 100000: ticks per output pulse period; must be ≥2.
- `PULSE_LEN`, 8: output pulse width in `clk_pps` cycles; must be 1..PPS_COUNT_VAL-1.
- `NUM_INCR`, 4: increment table entries; must be ≥2.
- `A_INCR_TABLE`, {32'hd554c987, 32'hd5543db8, 32'hd553b1ea, 32'hd5555555}: NUM_INCR*ACC_W bits, entry i at bits [i*ACC_W +: ACC_W]; reset contents.
- `clk_pps` in 1: the single clock.
- `reset_pps` in 1: reset, synchronous, active-high.
- `sel_next` in 1: one-cycle pulse, advance select.
- `sel_load` in 1: load select from `sel_val`.
- `sel_val` in $clog2(NUM_INCR): select value for `sel_load`.
- `incr_we` in 1: table write strobe (trim only).
- `incr_idx` in $clog2(NUM_INCR): table write index.
- `incr_data` in ACC_W: table write data.
- `pps_in` in 1: asynchronous input to timestamp.
- `ts_ack` in 1: consumer acknowledge of capture.
- `a_incr_sel` out $clog2(NUM_INCR): active table index.
- `tick` out 1: registered accumulator carry.
- `timestamp` out TS_W: running timestamp.
- `ts_capture` out TS_W: captured timestamp.
- `ts_valid` out 1: capture holds unread data.
- `ts_overrun` out 1: sticky, edge lost while valid.
- `pps_pulse_out` out 1: periodic pulse.

## Operation
- Accumulator: every cycle `acc <= acc + table[a_incr_sel]` mod 2^ACC_W; `tick <=` carry-out of that add.
- Timestamp: when `tick`=1, `timestamp <= timestamp + TIME_INCR_VAL` mod 2^TS_W (wraps silently).
- Period counter `cnt` 0..PPS_COUNT_VAL-1: increments on `tick`; on `tick` with `cnt`=PPS_COUNT_VAL-1 wraps to 0 and loads pulse counter with PULSE_LEN. `pps_pulse_out` = pulse counter ≠ 0; counter decrements each cycle when nonzero.
- Select: `sel_load` with `sel_val`<NUM_INCR loads it; `sel_val`≥NUM_INCR ignored. Else `sel_next` advances, NUM_INCR-1 wraps to 0. `sel_load` wins when both high.
- Capture: `pps_in` through 2-flop synchroniser plus edge register; rising edge detected on sync'd signal. Edge with `ts_valid`=0 or `ts_ack`=1: `ts_capture <= timestamp`, `ts_valid <= 1`. Edge with `ts_valid`=1 and `ts_ack`=0: capture held, `ts_overrun <= 1`. `ts_ack` without edge clears `ts_valid`. `ts_overrun` clears only on reset.

## Timing
- Reset (`reset_pps` high at an edge): acc, tick, timestamp, cnt, pulse counter, `ts_capture`, `ts_valid`, `ts_overrun`, synchroniser = 0; `a_incr_sel` = 0; table = A_INCR_TABLE. Reset mid-pulse ends the pulse next cycle.
- Select or table change applies to the add on the following edge (1-cycle latency).
- `timestamp` updates on the edge after `tick` is high; `pps_pulse_out` rises on the edge after the terminal tick, stays high exactly PULSE_LEN cycles.
- `pps_in` rising at an edge reaches `ts_valid` 3 edges later; captured value is `timestamp` in the cycle before that edge.

## Configuration
- `PPS_TIMER_TRIM_EN` defined: `incr_we` writes `incr_data` to entry `incr_idx` on the next edge; `incr_idx`≥NUM_INCR ignored; writing the active entry affects the next add.
- Undefined: table is constant A_INCR_TABLE; `incr_we`, `incr_idx`, `incr_data` ignored; no table registers inferred.

## Test plan
- ACC_W=4, table entry 0 = 4'h8, PPS_COUNT_VAL=4, PULSE_LEN=2: `tick` every 2nd cycle, `timestamp` +10 per tick, `pps_pulse_out` high 2 cycles every 8.
- Defaults, 30 cycles after reset: `a_incr_sel`=0, acc=30*0xd5555555 mod 2^32, timestamp matches tick count *10.
- `sel_next` x5 with NUM_INCR=4 -> sel 1,2,3,0,1; `sel_load`=2 with `sel_next` same cycle -> 2; `sel_val`=5 (NUM_INCR=5... use 4) `sel_val` out of range impossible at width 2, so NUM_INCR=3, `sel_val`=3 -> ignored.
- `pps_in` edge -> `ts_valid`=1 after 3 edges, capture correct; second edge before ack -> capture unchanged, `ts_overrun`=1; edge coincident with `ts_ack` -> new capture, `ts_valid` stays 1.
- TRIM_EN: write idx 0 = 4'h4 while active -> tick period becomes 4 cycles from next add; idx ≥NUM_INCR write no effect; without macro, same writes no effect.
- TS_W=8, timestamp at 250, tick -> wraps to 4; reset asserted mid-pulse -> all outputs 0 next cycle.
